// File: rtl/srn_deser.sv
// Serial-to-parallel deserializer: takes 0..LANES bits per beat under a
// thermometer valid mask and emits WIDTH-bit words with zero-latency valid.
module srn_deser #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 2,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] datain,
  input  logic [LANES-1:0] ctrl,
  input  logic             flush,
  output logic [WIDTH-1:0] dataout,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             err_ctrl
);

  // acc_q always holds received bits in arrival order with the newest bit at [0];
  // bits above position count_q are stale and are shifted out before use.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [LANES-1:0] ctrl_plus1;
  logic             ctrl_legal;
  logic             ctrl_zero;

  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        r[i] = w[WIDTH-1-i];
      end
    end
    return r;
  endfunction

  // A thermometer code plus one is a power of two (or wraps to zero when all ones).
  assign ctrl_plus1 = ctrl + LANES'(1);
  assign ctrl_legal = ((ctrl & ctrl_plus1) == '0);
  assign ctrl_zero  = (ctrl == '0);

  always_comb begin
    int               cnt;
    int               pad;
    logic [WIDTH-1:0] word;
    logic             done;

    acc_d     = acc_q;
    count_d   = count_q;
    dataout_d = dataout_q;
    valid_d   = 1'b0;
    err_d     = err_q | ~ctrl_legal;
    cnt       = int'(count_q);
    pad       = 0;
    word      = '0;
    done      = 1'b0;

    if (ctrl_legal && !ctrl_zero) begin
      for (int i = LANES - 1; i >= 0; i--) begin
        if (ctrl[i]) begin
          acc_d = {acc_d[WIDTH-2:0], datain[i]};
          cnt   = cnt + 1;
          if (cnt == WIDTH) begin
            word = acc_d;
            done = 1'b1;
            cnt  = 0;
          end
        end
      end
      count_d = CW'(cnt);
      if (done) begin
        dataout_d = orient(word);
        valid_d   = 1'b1;
      end
    end else if (ctrl_zero && flush && (count_q != '0)) begin
      pad       = WIDTH - int'(count_q);
      dataout_d = orient(acc_q << pad);
      valid_d   = 1'b1;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q     <= '0;
      count_q   <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign dataout  = dataout_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign err_ctrl = err_q;

endmodule

// File: tb/tb_srn_deser.sv
// Directed scoreboard bench for srn_deser (WIDTH=16, LANES=2), with a second
// MSB_FIRST=0 instance sharing the stimulus for bit-order checks.
module tb_srn_deser;
  localparam int W  = 16;
  localparam int L  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [L-1:0]  datain = '0;
  logic [L-1:0]  ctrl = '0;
  logic          flush = 1'b0;
  logic [W-1:0]  dataout, dataout_l;
  logic          valid, valid_l;
  logic [CW-1:0] count, count_l;
  logic          err_ctrl, err_l;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  srn_deser #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .datain(datain), .ctrl(ctrl), .flush(flush),
    .dataout(dataout), .valid(valid), .count(count), .err_ctrl(err_ctrl)
  );

  srn_deser #(.WIDTH(W), .LANES(L), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .datain(datain), .ctrl(ctrl), .flush(flush),
    .dataout(dataout_l), .valid(valid_l), .count(count_l), .err_ctrl(err_l)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One beat: drive, clock, then compare valid/dataout against the scoreboard.
  task automatic step(input string tag, input logic [L-1:0] d, input logic [L-1:0] c,
                      input logic f);
    logic [W-1:0] e;
    logic         pending;
    datain = d;
    ctrl   = c;
    flush  = f;
    @(posedge clk);
    #1;
    pending = (exp_q.size() > 0);
    chk({tag, ".valid"}, 64'(valid), 64'(pending));
    if (pending) begin
      e = exp_q.pop_front();
      if (valid) chk({tag, ".dataout"}, 64'(dataout), 64'(e));
    end
    $display("beat %-10s datain=%b ctrl=%b flush=%b -> valid=%b dataout=0x%h count=%0d err=%b",
             tag, d, c, f, valid, dataout, count, err_ctrl);
    datain = '0;
    ctrl   = '0;
    flush  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] held;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 64'(count), 64'(0));
    chk("rst.valid", 64'(valid), 64'(0));
    chk("rst.dataout", 64'(dataout), 64'(0));
    chk("rst.err", 64'(err_ctrl), 64'(0));
    rst = 1'b1;

    // Single-bit beats
    w = 16'h817E;
    for (int k = W - 1; k >= 0; k--) begin
      if (k == 0) exp_q.push_back(w);
      step("single", {1'b0, w[k]}, 2'b01, 1'b0);
    end
    chk("single.count", 64'(count), 64'(0));

    // dataout holds across idle cycles
    held = dataout;
    step("idle", 2'b11, 2'b00, 1'b0);
    chk("idle.hold", 64'(dataout), 64'(held));

    // Two-bit beats
    for (int j = 7; j >= 0; j--) begin
      if (j == 0) exp_q.push_back(w);
      step("double", {w[2*j+1], w[2*j]}, 2'b11, 1'b0);
    end
    chk("double.count", 64'(count), 64'(0));

    // Carry-over across a word boundary
    for (int k = W - 1; k >= 1; k--) step("carry", {1'b0, w[k]}, 2'b01, 1'b0);
    chk("carry.count15", 64'(count), 64'(15));
    exp_q.push_back(w);
    step("carry_end", 2'b01, 2'b11, 1'b0);
    chk("carry.count1", 64'(count), 64'(1));
    exp_q.push_back(16'h8000);
    step("carry_fl", 2'b00, 2'b00, 1'b1);
    chk("carry.flcount", 64'(count), 64'(0));

    // Flush, MSB-first and LSB-first placement
    step("fl_b0", 2'b01, 2'b01, 1'b1);  // flush ignored when ctrl != 0
    chk("flush.ignored_cnt", 64'(count), 64'(1));
    step("fl_b1", 2'b00, 2'b01, 1'b0);
    step("fl_b2", 2'b01, 2'b01, 1'b0);
    step("fl_b3", 2'b01, 2'b01, 1'b0);
    step("fl_b4", 2'b00, 2'b01, 1'b0);
    chk("flush.count5", 64'(count), 64'(5));
    exp_q.push_back(16'hB000);
    step("flush", 2'b00, 2'b00, 1'b1);
    chk("flush.count", 64'(count), 64'(0));
    chk("flush.lsb_valid", 64'(valid_l), 64'(1));
    chk("flush.lsb_dataout", 64'(dataout_l), 64'(16'h000D));
    step("flush2", 2'b00, 2'b00, 1'b1);
    chk("flush2.dataout", 64'(dataout), 64'(16'hB000));
    chk("flush.err", 64'(err_ctrl), 64'(0));

    // Illegal control code
    step("ill_b0", 2'b01, 2'b01, 1'b0);
    step("ill_b1", 2'b01, 2'b01, 1'b0);
    step("ill_b2", 2'b00, 2'b01, 1'b0);
    step("illegal", 2'b11, 2'b10, 1'b0);
    chk("illegal.count", 64'(count), 64'(3));
    chk("illegal.err", 64'(err_ctrl), 64'(1));
    for (int k = 0; k < 4; k++) step("ill_post", 2'b01, 2'b01, 1'b0);
    chk("illegal.count7", 64'(count), 64'(7));
    chk("illegal.err_hold", 64'(err_ctrl), 64'(1));

    // Mid-word reset, with an active beat in the same cycle
    rst    = 1'b0;
    datain = 2'b11;
    ctrl   = 2'b11;
    @(posedge clk);
    #1;
    chk("mrst.count", 64'(count), 64'(0));
    chk("mrst.valid", 64'(valid), 64'(0));
    chk("mrst.dataout", 64'(dataout), 64'(0));
    chk("mrst.err", 64'(err_ctrl), 64'(0));
    rst = 1'b1;
    w = 16'hA5C3;
    for (int j = 7; j >= 0; j--) begin
      if (j == 0) exp_q.push_back(w);
      step("post_rst", {w[2*j+1], w[2*j]}, 2'b11, 1'b0);
    end
    chk("post_rst.count", 64'(count), 64'(0));
    chk("scoreboard.empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/srn_deser.md
SRN_DESER -- requirements
Module: srn_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the output word width in bits (legal 4..64).
REQ-002 SHALL have parameter LANES, default 2, the maximum bits accepted per beat (legal 1..8, LANES <= WIDTH).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 places the first received bit at dataout[WIDTH-1]; 0 places it at dataout[0].
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port datain  input  LANES  serial bits for this beat.
REQ-007 SHALL have port ctrl  input  LANES  thermometer mask; the low n bits set means datain[n-1:0] are valid.
REQ-008 SHALL have port flush  input  1  emits the partial word zero-padded.
REQ-009 SHALL have port dataout  output  WIDTH  the last completed word.
REQ-010 SHALL have port valid  output  1  one-cycle pulse marking a new dataout.
REQ-011 SHALL have port count  output  max(1,$clog2(WIDTH))  bits currently held in the partial word (0..WIDTH-1).
REQ-012 SHALL have port err_ctrl  output  1  sticky flag for an illegal ctrl code.

Function
REQ-013 SHALL treat ctrl as legal only when it is zero or of the form 2^n-1 (n = 1..LANES); n is then the beat size.
REQ-014 SHALL ignore an illegal ctrl beat entirely (no bits taken, count unchanged) and set err_ctrl, which holds until reset.
REQ-015 SHALL consume a beat's bits in the order datain[n-1] first through datain[0] last.
REQ-016 SHALL, when count+n < WIDTH, append the n bits to the partial word and set count to count+n with valid=0.
REQ-017 SHALL, when count+n >= WIDTH, complete the word with the first WIDTH-count bits, register it on dataout with valid=1 at the same clock edge, and start the next word with the remaining count+n-WIDTH bits.
REQ-018 SHALL drive valid for exactly one cycle per completed word, meaning zero-cycle latency from the sampling edge.
REQ-019 SHALL hold dataout unchanged between valid pulses.
REQ-020 SHALL, when flush=1, ctrl=0 and count>0, output the count held bits zero-padded, pulse valid, and set count to 0.
REQ-021 SHALL place those bits at the top (dataout[WIDTH-1:WIDTH-count]) when MSB_FIRST=1, and at the bottom when MSB_FIRST=0.
REQ-022 SHALL treat flush=1 with count=0 as a no-op (no valid pulse).
REQ-023 SHALL ignore flush whenever ctrl != 0; the beat is processed normally and err_ctrl is unaffected.
REQ-024 SHALL leave state unchanged and hold valid=0 when ctrl=0 and flush=0.
REQ-025 SHALL keep count < WIDTH at all times; count wraps to the remainder, never to WIDTH.

Reset
REQ-026 SHALL, at any rising clk edge with rst=0, set count=0, dataout=0, valid=0, err_ctrl=0, and clear the partial word.
REQ-027 SHALL give reset priority over datain, ctrl and flush, including mid-word and in the same cycle as a completing beat; held bits are discarded.
REQ-028 SHALL resume normal operation on the first edge with rst=1.

Verification (WIDTH=16, LANES=2, MSB_FIRST=1 unless stated)
REQ-029 SHALL check single-bit beats: 16 beats of ctrl=01 carrying 0x817E MSB first -> one valid pulse, dataout=0x817E, count=0.
REQ-030 SHALL check two-bit beats: 8 beats of ctrl=11, datain={b(k),b(k-1)} of 0x817E -> one valid pulse after the 8th beat, dataout=0x817E.
REQ-031 SHALL check carry-over: 15 bits of 0x817E (b15..b1) at ctrl=01, then ctrl=11 with datain=2'b01 -> valid, dataout=0x817E, count=1; the next word begins with 1.
REQ-032 SHALL check flush: bits 1,0,1,1,0 then flush=1 with ctrl=0 -> valid, dataout=0xB000, count=0; a second flush gives no valid; with MSB_FIRST=0 the same bits give dataout=0x000D.
REQ-033 SHALL check illegal control: ctrl=10 at count=3 -> count stays 3, no valid, err_ctrl=1 and held through later legal beats.
REQ-034 SHALL check mid-word reset: rst=0 for one cycle after 7 bits with err_ctrl=1 -> count=0, valid=0, dataout=0x0000, err_ctrl=0; the next 16 bits of 0xA5C3 -> dataout=0xA5C3.
